therm_decoder: RTL and testbench

- Decodes an N-bit thermometer word back to the integer that produced it. This is the receive end of the thermometer encoder in which bit i = 0 for i < x and bit i = 1 for i >= x.
- Flags malformed ("bubbled") words and keeps a saturating error count.
- Sits between a thermometer-coded source (DAC/ADC-style sliced bus) and binary downstream logic.
- Uses a valid/ready handshake on both sides, with a 2-stage registered pipeline.

---
 rtl/therm_pkg.sv | 46 ++++
 rtl/therm_decoder_pipe_stage.sv | 46 ++++
 rtl/therm_decoder.sv | 89 ++++++++
 tb/tb_therm_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/therm_pkg.sv
// rtl/therm_pkg.sv - shared defaults and thermometer-code helper functions
package therm_pkg;

    localparam int THERM_N_DEFAULT  = 5;
    localparam int THERM_CW_DEFAULT = 8;
    localparam int THERM_MAX_N      = 64;
    localparam int THERM_MAX_VW     = 7;

    // Helpers take a word zero-extended to the widest legal size plus the live width,
    // so one definition serves every instance regardless of its N.
    function automatic logic [THERM_MAX_VW-1:0] therm_zero_count(
        input logic [THERM_MAX_N-1:0] word,
        input int                     n
    );
        logic [THERM_MAX_VW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < THERM_MAX_N; i++) begin
            if ((i < n) && !word[i]) begin
                cnt = cnt + 7'd1;
            end
        end
        return cnt;
    endfunction

    // Scanning from the top down, any 1 seen after a 0 is a 1 sitting below a 0.
    function automatic logic therm_is_bubbled(
        input logic [THERM_MAX_N-1:0] word,
        input int                     n
    );
        logic seen_zero;
        logic bubbled;
        seen_zero = 1'b0;
        bubbled   = 1'b0;
        for (int i = THERM_MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                if (!word[i]) begin
                    seen_zero = 1'b1;
                end else if (seen_zero) begin
                    bubbled = 1'b1;
                end
            end
        end
        return bubbled;
    endfunction

endpackage

// File: rtl/therm_decoder_pipe_stage.sv
// rtl/therm_decoder_pipe_stage.sv - valid/ready register slice (therm_pipe_stage)
module therm_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Ready whenever the slot is empty or is being drained this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/therm_decoder.sv
// rtl/therm_decoder.sv - thermometer-to-binary decoder with bubble flag and error counter
module therm_decoder
    import therm_pkg::*;
#(
    parameter int N  = THERM_N_DEFAULT,
    parameter int VW = $clog2(N + 1),
    parameter int CW = THERM_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_therm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] out_value,
    output logic          out_err,
    output logic [CW-1:0] err_count,
    input  logic          err_clear
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic                   s1_valid;
    logic                   s1_ready;
    logic [N-1:0]           s1_word;
    logic                   s2_ready;
    logic [VW:0]            s2_data;
    logic [THERM_MAX_N-1:0] s1_word_ext;
    logic [VW-1:0]          dec_value;
    logic                   dec_err;
    logic                   cnt_inc;
    logic [CW-1:0]          err_count_q;
    logic [CW-1:0]          err_count_d;

    therm_pipe_stage #(.W(N)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s1_ready),
        .in_data   (in_therm),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_word)
    );

    assign in_ready    = s1_ready;
    assign s1_word_ext = THERM_MAX_N'(s1_word);
    assign dec_value   = VW'(therm_zero_count(s1_word_ext, N));
    assign dec_err     = therm_is_bubbled(s1_word_ext, N);

    therm_pipe_stage #(.W(VW + 1)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   ({dec_err, dec_value}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign out_value = s2_data[VW-1:0];
    assign out_err   = s2_data[VW];

    // Counted when the bad word enters stage 2, not when it leaves.
    assign cnt_inc = s1_valid && s2_ready && dec_err;

    always_comb begin
        err_count_d = err_count_q;
        if (err_clear) begin
            err_count_d = '0;
        end
        if (cnt_inc && (err_count_d != CNT_MAX)) begin
            err_count_d = err_count_d + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_therm_decoder.sv
// tb/tb_therm_decoder.sv - randomized self-checking bench for therm_decoder
module tb_therm_decoder;

    localparam int N  = 5;
    localparam int VW = $clog2(N + 1);
    localparam logic [N-1:0] MASK = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          err_clear = 1'b0;
    logic [N-1:0]  in_therm = '0;
    logic          in_ready, out_valid, out_err;
    logic [VW-1:0] out_value;
    logic [7:0]    err_count;
    logic          in_ready_c, out_valid_c, out_err_c;
    logic [VW-1:0] out_value_c;
    logic [1:0]    err_count_c;

    int n_vec = 0;
    int n_err = 0;
    int model_errs = 0;
    int popped = 0;

    typedef struct {
        int value;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    therm_decoder #(.N(N), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_therm(in_therm),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_err(out_err),
        .err_count(err_count), .err_clear(err_clear)
    );

    therm_decoder #(.N(N), .CW(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_therm(in_therm),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_value(out_value_c), .out_err(out_err_c),
        .err_count(err_count_c), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    // value is the zero count; a legal word is exactly MASK shifted left by that count
    function automatic exp_t ref_model(input logic [N-1:0] w);
        exp_t e;
        logic [N-1:0] legal;
        e.value = N - $countones(w);
        legal   = MASK << e.value;
        e.err   = (w != legal);
        return e;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Scoreboard: transfers are decided by the levels seen at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            model_errs = 0;
        end else begin
            if (out_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got value=%0d err=%0d, required no output", out_value, out_err);
                end else if (int'(out_value) != exp_q[0].value || out_err !== exp_q[0].err) begin
                    n_err++;
                    $display("FAIL output_data: got value=%0d err=%0d, required value=%0d err=%0d",
                             out_value, out_err, exp_q[0].value, exp_q[0].err);
                end
                if (out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                mon_e = ref_model(in_therm);
                exp_q.push_back(mon_e);
                if (mon_e.err) model_errs++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clear = 1'b0;
        repeat (3) tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_vec++; if (out_value !== '0) begin n_err++; $display("FAIL reset_out_value: got %0d, required 0", out_value); end
        n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %b, required 0", out_err); end
        n_vec++; if (err_count !== 8'd0 || err_count_c !== 2'd0) begin n_err++; $display("FAIL reset_err_count: got %0d/%0d, required 0/0", err_count, err_count_c); end
        rst = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid: got %b, required 0", out_valid); end
    endtask

    task automatic test_legal_sweep();
        logic [N-1:0] words [6];
        words = '{5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin in_valid = 1'b1; in_therm = words[k]; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (k < 6) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sweep_in_ready[%0d]: got %b, required 1", k, in_ready); end
            end
            tick();
            n_vec++;
            if (k >= 1 && k <= 6) begin
                if (out_valid !== 1'b1 || out_value !== VW'(k - 1) || out_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL sweep_latency[%0d]: got valid=%b value=%0d err=%b, required valid=1 value=%0d err=0",
                             k, out_valid, out_value, out_err, k - 1);
                end
            end else if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL sweep_idle[%0d]: got valid=%b, required 0", k, out_valid);
            end
        end
        n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL sweep_err_count: got %0d, required 0", err_count); end
    endtask

    task automatic test_bubble();
        logic [N-1:0] words [2];
        int ev [2];
        int ec [2];
        words = '{5'b10110, 5'b00001};
        ev = '{2, 4};
        ec = '{1, 2};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_therm = words[k];
            tick();
            in_valid = 1'b0;
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || int'(out_value) != ev[k] || out_err !== 1'b1 || int'(err_count) != ec[k]) begin
                n_err++;
                $display("FAIL bubble[%0d]: got valid=%b value=%0d err=%b count=%0d, required valid=1 value=%0d err=1 count=%0d",
                         k, out_valid, out_value, out_err, err_count, ev[k], ec[k]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] w [4];
        int idx;
        int pop0;
        for (int i = 0; i < 4; i++) w[i] = N'($urandom);
        idx = 0;
        pop0 = popped;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_therm = w[idx];
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        n_vec++; if (idx != 2) begin n_err++; $display("FAIL bp_accepted: got %0d, required 2", idx); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_valid = 1'b1; in_therm = w[idx];
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        n_vec++; if (popped - pop0 != 4) begin n_err++; $display("FAIL bp_emitted: got %0d, required 4", popped - pop0); end
    endtask

    task automatic test_counter_edges();
        logic [N-1:0] bad [4];
        bad = '{5'b00001, 5'b10101, 5'b01111, 5'b11011};
        out_ready = 1'b1;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        model_errs = 0;
        n_vec++; if (err_count !== 8'd0 || err_count_c !== 2'd0) begin n_err++; $display("FAIL clear_alone: got %0d/%0d, required 0/0", err_count, err_count_c); end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_therm = bad[k];
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        n_vec++; if (err_count_c !== 2'd3) begin n_err++; $display("FAIL cnt_saturate: got %0d, required 3", err_count_c); end
        n_vec++; if (int'(err_count) != model_errs) begin n_err++; $display("FAIL cnt_wide: got %0d, required %0d", err_count, model_errs); end
        in_valid = 1'b1; in_therm = 5'b01101;
        tick();
        in_valid = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_vec++; if (err_count !== 8'd1 || err_count_c !== 2'd1) begin n_err++; $display("FAIL clear_and_inc: got %0d/%0d, required 1/1", err_count, err_count_c); end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        model_errs = 1;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10 && in_ready; c++) begin
            in_valid = 1'b1; in_therm = 5'b00101;
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full: got valid=%b ready=%b, required 1/0", out_valid, in_ready); end
        rst = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || err_count !== 8'd0 || err_count_c !== 2'd0 || out_value !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got valid=%b count=%0d/%0d value=%0d, required 0 0/0 0", out_valid, err_count, err_count_c, out_value);
        end
        rst = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d]: got valid=1, required 0", c); end
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid && ($urandom % 4 != 0)) begin
                in_valid = 1'b1;
                if ($urandom % 3 == 0) in_therm = N'($urandom);
                else in_therm = MASK << $urandom_range(0, N);
            end
            out_ready = ($urandom % 4 != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d pending, required 0", exp_q.size()); end
        n_vec++; if (int'(err_count) != sat(model_errs, 255)) begin n_err++; $display("FAIL rand_count: got %0d, required %0d", err_count, sat(model_errs, 255)); end
        n_vec++; if (int'(err_count_c) != sat(model_errs, 3)) begin n_err++; $display("FAIL rand_count_c: got %0d, required %0d", err_count_c, sat(model_errs, 3)); end
    endtask

    initial begin
        test_reset();
        test_legal_sweep();
        test_bubble();
        test_backpressure();
        test_counter_edges();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
